// File: rtl/sc_hdlc_pkt_upload.sv
// HDLC receive packet upload engine: queues completed frame lengths and streams
// one frame per upload request from an FWFT byte FIFO onto an AXI-Stream master.
//
// state     | meaning
// ST_IDLE   | waiting for upload_req with a queued frame
// ST_STREAM | forwarding bytes until the tlast beat handshakes
// ST_DONE   | one-cycle completion pulse on upload_done
module sc_hdlc_pkt_upload #(
  parameter int LEN_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_eop_valid,
  input  logic [31:0] rx_eop_len,
  output logic        len_full,
  output logic [31:0] ovf_cnt,
  input  logic        upload_req,
  output logic        upload_busy,
  output logic        upload_done,
  output logic [31:0] pkt_length,
  output logic [31:0] pkt_cnt,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast
);

  localparam int AW = $clog2(LEN_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ovf_q, ovf_d;
  logic [31:0]   remaining_q, remaining_d;
  logic [31:0]   len_mem_q [LEN_DEPTH];

  logic full;
  logic push;
  logic pop;
  logic in_stream;
  logic hs;
  logic [31:0] head_len;

  // Full is judged on the registered count, so a same-cycle pop cannot make room.
  assign full      = (cnt_q == CW'(LEN_DEPTH));
  assign push      = rx_eop_valid && !full;
  assign pop       = (state_q == ST_IDLE) && upload_req && (cnt_q != '0);
  assign head_len  = len_mem_q[rd_ptr_q];
  assign in_stream = (state_q == ST_STREAM);

  assign m_axis_tvalid = in_stream && !fifo_empty;
  assign m_axis_tdata  = in_stream ? fifo_dout : 8'h00;
  assign m_axis_tlast  = in_stream && (remaining_q == 32'd1);
  assign hs            = m_axis_tvalid && m_axis_tready;
  assign fifo_rd_en    = hs;

  assign len_full    = full;
  assign ovf_cnt     = ovf_q;
  assign pkt_cnt     = {{(32-CW){1'b0}}, cnt_q};
  assign pkt_length  = (cnt_q != '0) ? head_len : 32'd0;
  assign upload_busy = (state_q != ST_IDLE);
  assign upload_done = (state_q == ST_DONE);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    ovf_d    = (rx_eop_valid && full) ? ovf_q + 32'd1 : ovf_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          remaining_d = head_len;
          state_d     = (head_len == 32'd0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (hs) begin
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      remaining_q <= remaining_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LEN_DEPTH; i++) len_mem_q[i] <= '0;
    end else if (push) begin
      len_mem_q[wr_ptr_q] <= rx_eop_len;
    end
  end

endmodule

// File: doc/sc_hdlc_pkt_upload.md
# sc_hdlc_pkt_upload

Packet upload engine for the HDLC receive path. It queues the byte length of each frame completed by the HDLC receiver and reports the queue depth (`pkt_cnt`) and head length (`pkt_length`) to the register UI. On each `upload_req` pulse from the register UI, it streams exactly one queued frame from the receive byte FIFO onto an AXI-Stream master, then reports completion.

## Interface
- `LEN_DEPTH`, 16: depth of the internal length queue; must be a power of 2 and ≥ 2.
- `clk` in 1: sole clock.
- `rstn` in 1: asynchronous, active-low reset.
- `rx_eop_valid` in 1: single-cycle pulse; the receiver has committed one frame to the byte FIFO.
- `rx_eop_len` in 32: byte count of that frame; 0 is legal.
- `len_full` out 1: length queue is full. The receiver must not pulse `rx_eop_valid` while this is high.
- `ovf_cnt` out 32: count of `rx_eop_valid` pulses dropped because the queue was full.
- `upload_req` in 1: single-cycle request to upload the head frame.
- `upload_busy` out 1: an upload is in progress.
- `upload_done` out 1: single-cycle pulse; the frame has been fully sent.
- `pkt_length` out 32: length of the head queue entry; 0 when the queue is empty.
- `pkt_cnt` out 32: number of queued frames.
- `fifo_dout` in 8: head byte of the external first-word-fall-through byte FIFO.
- `fifo_empty` in 1: byte FIFO is empty.
- `fifo_rd_en` out 1: pops one byte from the byte FIFO.
- `m_axis_tdata` out 8: stream data.
- `m_axis_tvalid` out 1: stream valid.
- `m_axis_tready` in 1: stream ready.
- `m_axis_tlast` out 1: marks the last byte of the frame.

## Operation
**Length queue**
- Circular buffer of `LEN_DEPTH` × 32 bits, with read/write pointers and an occupancy count.
- Write on `rx_eop_valid && !len_full`.
- If `rx_eop_valid` arrives while full:
  - the entry is dropped and `ovf_cnt` increments (wrapping at 2^32);
  - full is evaluated before any same-cycle pop, so the write is rejected even if a pop happens in that cycle.
- Pointers wrap modulo `LEN_DEPTH`.
- `pkt_cnt`:
  - +1 on an accepted write;
  - −1 on a pop;
  - unchanged when both happen in the same cycle.
- `pkt_length` = queue head entry when `pkt_cnt > 0`, else 0.

**State machine: IDLE, STREAM, DONE**
- **IDLE**
  - `upload_req && pkt_cnt > 0`: pop the head into a 32-bit `remaining` register.
    - `remaining == 0` → DONE (zero-length frame; no beats are sent).
    - otherwise → STREAM.
  - `upload_req` with `pkt_cnt == 0`: ignored; stay in IDLE.
- **STREAM**
  - `m_axis_tvalid = !fifo_empty`.
  - `m_axis_tdata = fifo_dout`.
  - `m_axis_tlast = (remaining == 1)`.
  - On handshake (`tvalid && tready`):
    - `fifo_rd_en = 1`;
    - `remaining` decrements;
    - if this was the `tlast` beat → DONE.
- **DONE**
  - `upload_done = 1` for exactly one cycle, then → IDLE.
- `upload_busy` = 1 in STREAM and DONE, 0 in IDLE.
- `upload_req` is ignored outside IDLE; requests are not queued.
- `fifo_rd_en` is 0 outside STREAM handshakes.
- `m_axis_tvalid` and `m_axis_tlast` are 0 outside STREAM.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - state goes to IDLE; queue is emptied; pointers, `pkt_cnt`, `ovf_cnt` and `remaining` are cleared;
  - all outputs are 0, including `pkt_length`, `len_full`, `upload_busy`, `upload_done`, `fifo_rd_en`, `m_axis_tvalid` and `m_axis_tlast`.
  - Reset during STREAM abandons the frame. Bytes left in the external FIFO are the receiver's responsibility; it resets in the same domain.
- **Latency**
  - `rx_eop_valid` at cycle N → `pkt_cnt`, `pkt_length` and `len_full` update at N+1.
  - `upload_req` accepted at cycle N → `upload_busy` = 1 at N+1, and `m_axis_tvalid` may assert at N+1.
  - `pkt_cnt` decrements at N+1.
- **Streaming rate**
  - One byte per cycle when `tready` is held high and the byte FIFO is non-empty.
  - A frame of L ≥ 1 bytes with no stalls: STREAM lasts L cycles, `upload_done` pulses in the next cycle, and IDLE is re-entered after that.
  - A zero-length frame: DONE occupies the cycle after acceptance.
- **Back-pressure**
  - While `tready` = 0, `tdata` and `tlast` stay stable and no pop occurs.
  - `tvalid` drops only when `fifo_empty` = 1, i.e. an upstream underrun. The byte FIFO's FWFT head keeps `tdata` stable.
- **Concurrency**: a write and a pop in the same cycle are both honoured, subject to the full-before-pop rule.
- **Output registering**
  - `upload_done`, `upload_busy`, `pkt_cnt` and `len_full` are registered.
  - `m_axis_*` and `fifo_rd_en` are combinational from state and inputs.

## Test plan
- Push lengths 3 and 5; pulse `upload_req` with `tready` = 1 → bytes B0..B2 with `tlast` on B2; `upload_done` 1 cycle later; `pkt_cnt` goes 2→1 and `pkt_length` = 5.
- Queue length 4; toggle `tready` 1,0,1,0… → exactly 4 handshakes with `tdata` stable during stalls, `tlast` only on the 4th, and 4 `fifo_rd_en` pulses.
- Queue length 0, then pulse `upload_req` → no `tvalid`; `upload_done` at N+1; `pkt_cnt` 1→0.
- Fill with 16 entries (`LEN_DEPTH` = 16), then pulse `rx_eop_valid` twice → `len_full` = 1, `ovf_cnt` = 2, `pkt_cnt` = 16. Pop all 16 and check that `pkt_length` sequence equals the pushed order across pointer wrap.
- Pulse `upload_req` with `pkt_cnt` = 0, and again during busy → both ignored; `upload_busy` stays unchanged.
- Deassert `rstn` mid-STREAM after 2 of 6 bytes → all outputs 0 immediately; `pkt_cnt` = 0 after release; a new length 2 then uploads correctly.
